// File: rtl/display_pkg.sv
// Shared definitions for the display scan controller: FSM state encoding,
// segment constants (active-low, bit 6 = g) and a ceil(log2) helper.
package display_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CONV   = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;
   localparam logic [6:0] SEG_ZERO  = 7'b1000000;

   // ceil(log2(value)), never less than 1 so it can size a register
   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result = result + 1;
         rem    = rem >>> 1;
      end
      if (result < 1) begin
         result = 1;
      end else begin
         result = result;
      end
      return result;
   endfunction

endpackage

// File: rtl/bin_to_bcd_serial.sv
// Serial shift-add-3 (double dabble) binary to BCD converter, one input bit
// per step. Internally it keeps enough BCD digits for any W-bit value, so
// anything beyond the DIGITS displayed digits is reported as ovf.
module bin_to_bcd_serial #(
   parameter int W      = 8,
   parameter int DIGITS = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                step,
   input  logic [W-1:0]        bin,
   output logic [4*DIGITS-1:0] bcd,
   output logic                ovf
);

   // (W+2)/3 decimal digits always hold 2^W-1
   localparam int ND_FULL = (W + 2) / 3;
   localparam int ND_INT  = (ND_FULL > DIGITS) ? ND_FULL : DIGITS;
   localparam int BW      = 4 * ND_INT;

   logic [W-1:0]  shreg_r;
   logic [BW-1:0] bcd_r;
   logic [BW-1:0] adj_s;

   // Add 3 to every BCD digit that is 5 or more before the next shift
   always_comb begin
      adj_s = bcd_r;
      for (int i = 0; i < ND_INT; i++) begin
         if (bcd_r[4*i +: 4] >= 4'd5) begin
            adj_s[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
         end else begin
            adj_s[4*i +: 4] = bcd_r[4*i +: 4];
         end
      end
   end

   // Operand shift register and BCD accumulator
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg_r <= '0;
         bcd_r   <= '0;
      end else if (start) begin
         shreg_r <= bin;
         bcd_r   <= '0;
      end else if (step) begin
         shreg_r <= {shreg_r[W-2:0], 1'b0};
         bcd_r   <= {adj_s[BW-2:0], shreg_r[W-1]};
      end else begin
         shreg_r <= shreg_r;
         bcd_r   <= bcd_r;
      end
   end

   assign bcd = bcd_r[4*DIGITS-1:0];

   generate
      if (ND_INT > DIGITS) begin : g_ovf
         assign ovf = |bcd_r[BW-1:4*DIGITS];
      end else begin : g_no_ovf
         assign ovf = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/decoder_7seg.sv
// BCD digit to active-low seven-segment pattern (bit 6 = g .. bit 0 = a).
// Codes above 9 decode to a blank digit.
module decoder_7seg
   import display_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   // Pure lookup of the segment pattern for one digit
   always_comb begin
      seg = SEG_BLANK;
      case (bcd)
         4'd0:    seg = 7'b1000000;
         4'd1:    seg = 7'b1111001;
         4'd2:    seg = 7'b0100100;
         4'd3:    seg = 7'b0110000;
         4'd4:    seg = 7'b0011001;
         4'd5:    seg = 7'b0010010;
         4'd6:    seg = 7'b0000010;
         4'd7:    seg = 7'b1111000;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0010000;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/display_scan_controller.sv
// Multiplexed signed/unsigned decimal display driver.
// A load in IDLE captures num/is_signed, converts the magnitude serially in
// W cycles, commits the new digits in one COMMIT cycle and returns to IDLE.
// A free-running refresh counter scans the DIGITS magnitude positions plus
// the sign position (bit DIGITS of an). seg and an are registered.
// Optional feature: define DISPLAY_LZB_EN to blank leading zero digits.
module display_scan_controller
   import display_pkg::*;
#(
   parameter int W        = 8,
   parameter int DIGITS   = 3,
   parameter int SCAN_DIV = 50000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [W-1:0]    num,
   input  logic            is_signed,
   input  logic            load,
   output logic            busy,
   output logic            ovf,
   output logic [6:0]      seg,
   output logic [DIGITS:0] an
);

   localparam int CW   = clog2(W);
   localparam int CNTW = clog2(SCAN_DIV);
   localparam int IW   = clog2(DIGITS + 1);

   state_t                state_r;
   state_t                state_nxt_s;
   logic [CW-1:0]         bit_cnt_r;
   logic                  start_s;
   logic                  step_s;
   logic                  commit_s;
   logic [W-1:0]          mag_s;
   logic                  neg_cap_r;
   logic [4*DIGITS-1:0]   bcd_s;
   logic                  conv_ovf_s;

   logic [4*DIGITS-1:0]   digits_r;
   logic [4*DIGITS-1:0]   digits_nxt_s;
   logic                  neg_disp_r;
   logic                  neg_nxt_s;
   logic                  ovf_r;
   logic                  ovf_nxt_s;
   logic [CNTW-1:0]       cnt_r;
   logic [CNTW-1:0]       cnt_nxt_s;
   logic [IW-1:0]         idx_r;
   logic [IW-1:0]         idx_nxt_s;
   logic [DIGITS:0]       an_r;
   logic [DIGITS:0]       an_nxt_s;
   logic [6:0]            seg_r;
   logic [6:0]            seg_nxt_s;
   logic                  busy_r;
   logic [3:0]            sel_bcd_s;
   logic [6:0]            dec_seg_s;
   logic                  blank_s;

   // Two's complement negate only for signed negative inputs; -2^(W-1) maps to 2^(W-1)
   assign mag_s = (is_signed && num[W-1]) ? (~num + {{(W-1){1'b0}}, 1'b1}) : num;

   bin_to_bcd_serial #(
      .W      (W),
      .DIGITS (DIGITS)
   ) u_conv (
      .clk   (clk),
      .rst   (rst),
      .start (start_s),
      .step  (step_s),
      .bin   (mag_s),
      .bcd   (bcd_s),
      .ovf   (conv_ovf_s)
   );

   // FSM next state and converter control; load is only honoured in IDLE
   always_comb begin
      state_nxt_s = state_r;
      start_s     = 1'b0;
      step_s      = 1'b0;
      commit_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (load) begin
               start_s     = 1'b1;
               state_nxt_s = ST_CONV;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_CONV: begin
            step_s = 1'b1;
            if (bit_cnt_r == CW'(W - 1)) begin
               state_nxt_s = ST_COMMIT;
            end else begin
               state_nxt_s = ST_CONV;
            end
         end
         ST_COMMIT: begin
            commit_s    = 1'b1;
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // FSM state, conversion bit counter, captured sign and busy flag
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         bit_cnt_r <= '0;
         neg_cap_r <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         busy_r  <= (state_nxt_s != ST_IDLE);
         if (start_s) begin
            bit_cnt_r <= '0;
            neg_cap_r <= is_signed & num[W-1];
         end else if (step_s) begin
            bit_cnt_r <= bit_cnt_r + CW'(1);
            neg_cap_r <= neg_cap_r;
         end else begin
            bit_cnt_r <= bit_cnt_r;
            neg_cap_r <= neg_cap_r;
         end
      end
   end

   // Next display contents (swapped atomically on COMMIT) and scan position
   always_comb begin
      digits_nxt_s = digits_r;
      neg_nxt_s    = neg_disp_r;
      ovf_nxt_s    = ovf_r;
      cnt_nxt_s    = cnt_r;
      idx_nxt_s    = idx_r;
      if (commit_s) begin
         digits_nxt_s = bcd_s;
         neg_nxt_s    = neg_cap_r;
         ovf_nxt_s    = conv_ovf_s;
      end else begin
         digits_nxt_s = digits_r;
      end
      if (cnt_r == CNTW'(SCAN_DIV - 1)) begin
         cnt_nxt_s = '0;
         if (idx_r == IW'(DIGITS)) begin
            idx_nxt_s = '0;
         end else begin
            idx_nxt_s = idx_r + IW'(1);
         end
      end else begin
         cnt_nxt_s = cnt_r + CNTW'(1);
         idx_nxt_s = idx_r;
      end
   end

   // Pick the BCD digit shown at the next scan position
   always_comb begin
      sel_bcd_s = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_nxt_s == IW'(i)) begin
            sel_bcd_s = digits_nxt_s[4*i +: 4];
         end else begin
            sel_bcd_s = sel_bcd_s;
         end
      end
   end

   decoder_7seg u_dec (
      .bcd (sel_bcd_s),
      .seg (dec_seg_s)
   );

`ifdef DISPLAY_LZB_EN
   logic [DIGITS-1:0] lz_s;

   // lz_s[i]: digit i and every higher magnitude digit are zero; digit 0 is never blanked
   always_comb begin
      lz_s    = '0;
      blank_s = 1'b0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         if (i == DIGITS - 1) begin
            lz_s[i] = (digits_nxt_s[4*i +: 4] == 4'd0);
         end else begin
            lz_s[i] = (digits_nxt_s[4*i +: 4] == 4'd0) && lz_s[i+1];
         end
      end
      for (int i = 1; i < DIGITS; i++) begin
         if (idx_nxt_s == IW'(i)) begin
            blank_s = lz_s[i];
         end else begin
            blank_s = blank_s;
         end
      end
   end
`else
   // Leading zeros are always shown in this build
   assign blank_s = 1'b0;
`endif

   // Segment pattern and one-hot active-low anode for the next scan position
   always_comb begin
      an_nxt_s  = '1;
      seg_nxt_s = SEG_BLANK;
      for (int i = 0; i <= DIGITS; i++) begin
         if (idx_nxt_s == IW'(i)) begin
            an_nxt_s[i] = 1'b0;
         end else begin
            an_nxt_s[i] = 1'b1;
         end
      end
      if (idx_nxt_s == IW'(DIGITS)) begin
         seg_nxt_s = neg_nxt_s ? SEG_MINUS : SEG_BLANK;
      end else if (ovf_nxt_s) begin
         seg_nxt_s = SEG_MINUS;
      end else if (blank_s) begin
         seg_nxt_s = SEG_BLANK;
      end else begin
         seg_nxt_s = dec_seg_s;
      end
   end

   // Display registers, refresh counter, scan index and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         digits_r   <= '0;
         neg_disp_r <= 1'b0;
         ovf_r      <= 1'b0;
         cnt_r      <= '0;
         idx_r      <= '0;
         an_r       <= {{DIGITS{1'b1}}, 1'b0};
         seg_r      <= SEG_ZERO;
      end else begin
         digits_r   <= digits_nxt_s;
         neg_disp_r <= neg_nxt_s;
         ovf_r      <= ovf_nxt_s;
         cnt_r      <= cnt_nxt_s;
         idx_r      <= idx_nxt_s;
         an_r       <= an_nxt_s;
         seg_r      <= seg_nxt_s;
      end
   end

   assign busy = busy_r;
   assign ovf  = ovf_r;
   assign seg  = seg_r;
   assign an   = an_r;

endmodule

// File: tb/tb_display_scan_controller.sv
// Self-checking bench for display_scan_controller (W=8, SCAN_DIV=4).
// dut: DIGITS=3, dut2: DIGITS=2 (overflow cases). A reference model tracks
// the displayed value as an integer and derives busy/an/seg from it.
// Honours DISPLAY_LZB_EN when the bundle is built with it.
module tb_display_scan_controller;

   localparam int W  = 8;
   localparam int SD = 4;

   localparam logic [6:0] SB = 7'b1111111;
   localparam logic [6:0] SM = 7'b0111111;
   localparam logic [6:0] S0 = 7'b1000000;
   localparam logic [6:0] S1 = 7'b1111001;
   localparam logic [6:0] S2 = 7'b0100100;
   localparam logic [6:0] S4 = 7'b0011001;
   localparam logic [6:0] S5 = 7'b0010010;
   localparam logic [6:0] S7 = 7'b1111000;
   localparam logic [6:0] S8 = 7'b0000000;
`ifdef DISPLAY_LZB_EN
   localparam logic [6:0] Z = SB;
`else
   localparam logic [6:0] Z = S0;
`endif

   logic [6:0] dig_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
   logic [3:0] an_seq [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
   logic [6:0] ovf_exp [3] = '{SM, SM, SB};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, load, is_signed, load2, is_signed2;
   logic [7:0] num, num2;
   logic       busy, ovf, busy2, ovf2;
   logic [6:0] seg, seg2;
   logic [3:0] an;
   logic [2:0] an2;

   display_scan_controller #(.W(W), .DIGITS(3), .SCAN_DIV(SD)) dut (
      .clk(clk), .rst(rst), .num(num), .is_signed(is_signed), .load(load),
      .busy(busy), .ovf(ovf), .seg(seg), .an(an));

   display_scan_controller #(.W(W), .DIGITS(2), .SCAN_DIV(SD)) dut2 (
      .clk(clk), .rst(rst), .num(num2), .is_signed(is_signed2), .load(load2),
      .busy(busy2), .ovf(ovf2), .seg(seg2), .an(an2));

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // ---------------- reference model ----------------
   logic       ld_a [2];
   logic [7:0] nv_a [2];
   logic       sv_a [2];
   assign ld_a[0] = load;  assign nv_a[0] = num;  assign sv_a[0] = is_signed;
   assign ld_a[1] = load2; assign nv_a[1] = num2; assign sv_a[1] = is_signed2;

   int m_n;
   int m_left [2];
   int m_pval [2];
   bit m_pneg [2];
   int m_val  [2];
   bit m_neg  [2];
   bit m_ovf  [2];

   function automatic int nd_of(input int k);
      return (k == 0) ? 3 : 2;
   endfunction

   function automatic int mag(input logic [7:0] v, input logic s);
      if (s && v >= 8'd128) return 256 - int'(v);
      return int'(v);
   endfunction

   // Model: cycles since reset, busy window of W+1 cycles, value shown after it
   always @(posedge clk) begin
      if (rst) begin
         m_n <= 0;
         for (int k = 0; k < 2; k++) begin
            m_left[k] <= 0; m_val[k] <= 0; m_neg[k] <= 1'b0; m_ovf[k] <= 1'b0;
         end
      end else begin
         m_n <= m_n + 1;
         for (int k = 0; k < 2; k++) begin
            if (m_left[k] == 0) begin
               if (ld_a[k]) begin
                  m_left[k] <= W + 1;
                  m_pval[k] <= mag(nv_a[k], sv_a[k]);
                  m_pneg[k] <= sv_a[k] && nv_a[k][7];
               end
            end else begin
               m_left[k] <= m_left[k] - 1;
               if (m_left[k] == 1) begin
                  m_val[k] <= m_pval[k];
                  m_neg[k] <= m_pneg[k];
                  m_ovf[k] <= (m_pval[k] > (10 ** nd_of(k)) - 1);
               end
            end
         end
      end
   end

   function automatic logic [6:0] exp_seg(input int p, input int nd, input int val,
                                          input bit neg, input bit ov);
      int pw = 10 ** p;
      if (p == nd) return neg ? SM : SB;
      if (ov) return SM;
`ifdef DISPLAY_LZB_EN
      if (p > 0 && val < pw) return SB;
`endif
      return dig_tab[(val / pw) % 10];
   endfunction

   // ---------------- checking ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_model();
      int p, p2;
      p  = (m_n / SD) % 4;
      p2 = (m_n / SD) % 3;
      chk("m_busy", busy, (m_left[0] != 0));
      chk("m_ovf", ovf, m_ovf[0]);
      chk("m_an", an, 15 ^ (1 << p));
      chk("m_seg", seg, exp_seg(p, 3, m_val[0], m_neg[0], m_ovf[0]));
      chk("m_busy2", busy2, (m_left[1] != 0));
      chk("m_ovf2", ovf2, m_ovf[1]);
      chk("m_an2", an2, 7 ^ (1 << p2));
      chk("m_seg2", seg2, exp_seg(p2, 2, m_val[1], m_neg[1], m_ovf[1]));
   endtask

   task automatic tick();
      @(negedge clk);
      if (chk_en) check_model();
   endtask

   task automatic wait_idle();
      int k = 0;
      while (busy && k < 40) begin tick(); k++; end
      chk("wait_idle", busy, 0);
   endtask

   task automatic wait_idle2();
      int k = 0;
      while (busy2 && k < 40) begin tick(); k++; end
      chk("wait_idle2", busy2, 0);
   endtask

   // ---------------- vector table ----------------
   typedef struct packed {
      logic            sgn;
      logic [7:0]      num;
      logic [3:0][6:0] segs;   // [3]=sign, [2]=hundreds, [1]=tens, [0]=units
      logic            ovf;
   } vec_t;

   vec_t tbl [8];

   initial begin
      int cnt;
      int p;
      logic [6:0] seven_exp [4];

      tbl[0] = '{1'b1, 8'hF6, {SM, Z,  S1, S0}, 1'b0};
      tbl[1] = '{1'b1, 8'h80, {SM, S1, S2, S8}, 1'b0};
      tbl[2] = '{1'b0, 8'h80, {SB, S1, S2, S8}, 1'b0};
      tbl[3] = '{1'b0, 8'hFF, {SB, S2, S5, S5}, 1'b0};
      tbl[4] = '{1'b0, 8'h00, {SB, Z,  Z,  S0}, 1'b0};
      tbl[5] = '{1'b1, 8'h7F, {SB, S1, S2, S7}, 1'b0};
      tbl[6] = '{1'b1, 8'hFF, {SM, Z,  Z,  S1}, 1'b0};
      tbl[7] = '{1'b0, 8'h2A, {SB, Z,  S4, S2}, 1'b0};
      seven_exp = '{S7, Z, Z, SB};

      rst = 1'b1; load = 1'b0; load2 = 1'b0;
      num = 8'd0; num2 = 8'd0; is_signed = 1'b0; is_signed2 = 1'b0;
      tick();
      chk_en = 1'b1;
      tick();

      // reset state
      chk("rst_busy", busy, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_an", an, 4'b1110);
      chk("rst_seg", seg, 7'b1000000);
      rst = 1'b0;

      // anode scan sequence and wrap
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("scan_an", an, an_seq[((i + 1) / SD) % 4]);
      end

      // busy length for a signed load of -10
      wait_idle();
      is_signed = 1'b1; num = 8'hF6; load = 1'b1;
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         load = 1'b0;
         if (busy) cnt++;
      end
      chk("busy_len", cnt, W + 1);

      // table-driven values
      for (int v = 0; v < 8; v++) begin
         wait_idle();
         is_signed = tbl[v].sgn; num = tbl[v].num; load = 1'b1;
         tick();
         load = 1'b0;
         wait_idle();
         for (int j = 0; j < 16; j++) begin
            tick();
            p = (m_n / SD) % 4;
            chk($sformatf("tbl%0d_seg", v), seg, tbl[v].segs[p]);
            chk($sformatf("tbl%0d_ovf", v), ovf, tbl[v].ovf);
         end
      end

      // second load during conversion is ignored
      wait_idle();
      is_signed = 1'b0; num = 8'd7; load = 1'b1;
      tick(); load = 1'b0;
      tick(); tick();
      num = 8'd99; load = 1'b1;
      tick(); load = 1'b0;
      wait_idle();
      for (int j = 0; j < 16; j++) begin
         tick();
         p = (m_n / SD) % 4;
         chk("ignore_busy", busy, 0);
         chk("ignore_seg", seg, seven_exp[p]);
      end

      // overflow on the two-digit instance
      wait_idle2();
      is_signed2 = 1'b0; num2 = 8'd100; load2 = 1'b1;
      tick(); load2 = 1'b0;
      wait_idle2();
      chk("ovf2_flag", ovf2, 1);
      for (int j = 0; j < 12; j++) begin
         tick();
         p = (m_n / SD) % 3;
         chk("ovf2_seg", seg2, ovf_exp[p]);
      end

      // reset in the middle of a conversion
      wait_idle();
      is_signed = 1'b1; num = 8'h80; load = 1'b1;
      tick(); load = 1'b0;
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_ovf", ovf, 0);
      chk("mid_rst_an", an, 4'b1110);
      chk("mid_rst_seg", seg, 7'b1000000);
      rst = 1'b0;

      // randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         tick();
         rst        = ($urandom_range(0, 149) == 0);
         load       = ($urandom_range(0, 3) == 0);
         num        = 8'($urandom);
         is_signed  = 1'($urandom);
         load2      = ($urandom_range(0, 3) == 0);
         num2       = 8'($urandom);
         is_signed2 = 1'($urandom);
      end
      rst = 1'b0; load = 1'b0; load2 = 1'b0;
      for (int i = 0; i < 20; i++) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/display_scan_controller.md
DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

Interface
REQ-001 SHALL have parameter W, default 8, meaning input word width in bits (W >= 2).
REQ-002 SHALL have parameter DIGITS, default 3, meaning the number of decimal magnitude digits (DIGITS >= 1).
REQ-003 SHALL have parameter SCAN_DIV, default 50000, meaning clocks per digit dwell (SCAN_DIV >= 2).
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-006 SHALL have port num, input, W bits, value to display.
REQ-007 SHALL have port is_signed, input, 1 bit: 1 means num is two's complement, 0 means unsigned; sampled with load.
REQ-008 SHALL have port load, input, 1 bit, capture strobe.
REQ-009 SHALL have port busy, output, 1 bit, high while a conversion is in progress.
REQ-010 SHALL have port ovf, output, 1 bit, high when the committed magnitude exceeds 10^DIGITS-1.
REQ-011 SHALL have port seg, output, 7 bits, active-low segments, bit 6 = g.
REQ-012 SHALL have port an, output, DIGITS+1 bits, active-low one-hot digit select; bit DIGITS is the sign position.

Function
REQ-013 SHALL implement an FSM with states IDLE, CONV and COMMIT.
REQ-014 SHALL accept load only in IDLE; on acceptance it SHALL capture num and is_signed and enter CONV.
REQ-015 SHALL ignore load in CONV and COMMIT, with no queueing.
REQ-016 SHALL compute magnitude = -num when is_signed=1 and num[W-1]=1, else num, as a W-bit unsigned value; num = -2^(W-1) SHALL yield 2^(W-1).
REQ-017 SHALL perform shift-add-3 (double dabble) conversion in CONV, one bit per cycle, for exactly W cycles, then go to COMMIT for 1 cycle, then return to IDLE.
REQ-018 SHALL drive busy high in CONV and COMMIT, so a load accepted at edge k gives busy=1 for exactly W+1 cycles.
REQ-019 SHALL update the display registers (digits, sign, ovf) atomically at the COMMIT edge only; the previous value SHALL stay displayed during conversion.
REQ-020 SHALL, on overflow, set ovf=1 and show SEG_MINUS on every magnitude digit.
REQ-021 SHALL show SEG_MINUS in the sign position when the committed value is negative, else SEG_BLANK.
REQ-022 SHALL use a refresh counter that counts 0..SCAN_DIV-1; on wrap, the digit index SHALL advance 0,1,...,DIGITS,0.
REQ-023 SHALL assert an[index] low and all other an bits high, with seg showing that position.
REQ-024 SHALL scan continuously and independently of the FSM.

Reset
REQ-025 SHALL, when rst=1 at an edge, set FSM=IDLE, busy=0, ovf=0, refresh counter=0, index=0, magnitude digits=0 and sign=blank.
REQ-026 SHALL abort any conversion in progress on reset; after reset, an=all-ones except bit 0 low, and seg=7'b1000000 ("0").

Configuration
REQ-027 SHALL, with DISPLAY_LZB_EN defined, blank digit i (1..DIGITS-1) when it and all higher magnitude digits are 0; digit 0 SHALL never be blanked.
REQ-028 SHALL, without DISPLAY_LZB_EN, show all magnitude digits, including leading zeros.
REQ-029 SHALL apply no blanking while ovf=1, with or without DISPLAY_LZB_EN.

Structure
REQ-030 SHALL take SEG_BLANK (7'b1111111), SEG_MINUS (7'b0111111), the FSM state encoding and a clog2 helper from shared package display_pkg.
REQ-031 SHALL implement the serial converter as sub-module bin_to_bcd_serial; BCD-to-segment decoding SHALL reuse the existing decoder_7seg.

Verification (W=8, DIGITS=3, SCAN_DIV=4 unless stated)
REQ-032 SHALL cover: reset -> busy=0, ovf=0, an=4'b1110, seg=7'b1000000; an steps 1101, 1011, 0111 every 4 cycles and wraps after 16.
REQ-033 SHALL cover: is_signed=1, num=8'hF6, load -> busy high 9 cycles, then digits "-", blank, 1, 0 (sign, hundreds, tens, units; LZB on).
REQ-034 SHALL cover: is_signed=1, num=8'h80 -> "-128"; is_signed=0, num=8'h80 -> blank sign, "128"; is_signed=0, num=8'hFF -> "255".
REQ-035 SHALL cover: load of 8'd7, then load of 8'd99 three cycles later -> second load ignored, display shows 7.
REQ-036 SHALL cover: DIGITS=2, is_signed=0, num=8'd100 -> ovf=1, both magnitude digits show SEG_MINUS.
REQ-037 SHALL cover: rst asserted mid-CONV -> next cycle busy=0 and the display is at its reset value.
